// File: rtl/grs_pipe.sv
// -----------------------------------------------------------------------------
// grs_pipe -- guard/round/sticky extraction stage for the FP multiplier
//
// Takes the tail of the mantissa product (bits below the unshifted result LSB),
// the product overflow flag and the exponent-adder MSB flag. It then produces
// registered guard, round and sticky bits for the rounding unit.
//
// Two pipeline stages sit behind a valid/ready handshake:
//   S1 registers the tail, lsb_in, Mul_MSB and the aligned Ez_add_MSB.
//   S2 selects the alignment and reduces the tail to G/R/S.
// Ez_add_MSB arrives EZ_LEAD advances ahead of its tail. It is realigned by an
// advance-gated delay line, so it stays matched to its beat across stalls.
//
// Parameters
//   TAIL_W     tail width, minimum 3
//   EZ_LEAD    number of advances by which Ez_add_MSB leads its tail (0 = none)
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake (in_ready is combinational
//                               from out_ready and out_valid)
//   tail, lsb_in, Mul_MSB       product tail, unshifted LSB, overflow flag
//   Ez_add_MSB                  exponent-adder MSB, EZ_LEAD advances early
//   out_valid / out_ready       downstream handshake
//   guard, round_bit, sticky    extracted rounding bits (registered)
//   shifted                     1 when the right-normalised alignment was used
//
// Optional build macro RNE_INC_EN adds:
//   lsb_hi     (in)   result LSB for the shifted alignment, aligned with tail
//   round_inc  (out)  round-to-nearest-even increment, registered with G/R/S
// -----------------------------------------------------------------------------
module grs_pipe #(
    parameter int TAIL_W  = 23,
    parameter int EZ_LEAD = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAIL_W-1:0] tail,
    input  logic              lsb_in,
    input  logic              Mul_MSB,
    input  logic              Ez_add_MSB,
`ifdef RNE_INC_EN
    input  logic              lsb_hi,
    output logic              round_inc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              guard,
    output logic              round_bit,
    output logic              sticky,
    output logic              shifted
);

    // The whole pipe moves as one: it advances when the output slot is empty
    // or is being drained this cycle. Otherwise every register holds.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------------------------------------------------------------
    // Ez_add_MSB alignment
    // ---------------------------------------------------------------------
    logic ez_d;

    generate
        if (EZ_LEAD == 0) begin : g_no_ez_line
            assign ez_d = Ez_add_MSB;
        end else begin : g_ez_line
            logic [EZ_LEAD-1:0] ez_line_reg;

            // The line shifts on every advance, bubbles included. This matches
            // the upstream cadence, where the flag is also clocked per advance.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    ez_line_reg <= '0;
                end else if (advance) begin
                    for (int i = EZ_LEAD - 1; i > 0; i--) begin
                        ez_line_reg[i] <= ez_line_reg[i-1];
                    end
                    ez_line_reg[0] <= Ez_add_MSB;
                end
            end

            assign ez_d = ez_line_reg[EZ_LEAD-1];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Stage 1: capture
    // ---------------------------------------------------------------------
    logic              v1_reg;
    logic [TAIL_W-1:0] tail_s1_reg;
    logic              lsb_s1_reg;
    logic              mul_s1_reg;
    logic              ez_s1_reg;
`ifdef RNE_INC_EN
    logic              lsb_hi_s1_reg;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_reg        <= 1'b0;
            tail_s1_reg   <= '0;
            lsb_s1_reg    <= 1'b0;
            mul_s1_reg    <= 1'b0;
            ez_s1_reg     <= 1'b0;
`ifdef RNE_INC_EN
            lsb_hi_s1_reg <= 1'b0;
`endif
        end else if (advance) begin
            v1_reg <= in_valid;
            // Data flops only load real beats. Bubbles leave them untouched,
            // which saves toggling in the wide tail register.
            if (in_valid) begin
                tail_s1_reg   <= tail;
                lsb_s1_reg    <= lsb_in;
                mul_s1_reg    <= Mul_MSB;
                ez_s1_reg     <= ez_d;
`ifdef RNE_INC_EN
                lsb_hi_s1_reg <= lsb_hi;
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: alignment select and G/R/S reduction
    // ---------------------------------------------------------------------
    logic sel;
    logic guard_next;
    logic round_next;
    logic sticky_next;

    // On a 1-bit right normalise, the unshifted LSB becomes the guard bit and
    // every tail position moves one place further down.
    always_comb begin
        sel         = mul_s1_reg | ez_s1_reg;
        guard_next  = tail_s1_reg[TAIL_W-1];
        round_next  = tail_s1_reg[TAIL_W-2];
        sticky_next = |tail_s1_reg[TAIL_W-3:0];
        if (sel) begin
            guard_next  = lsb_s1_reg;
            round_next  = tail_s1_reg[TAIL_W-1];
            sticky_next = |tail_s1_reg[TAIL_W-2:0];
        end
    end

`ifdef RNE_INC_EN
    logic lsb_eff;
    logic round_inc_next;

    // Round half to even: increment above half, or at exactly half when the
    // kept LSB is odd.
    always_comb begin
        lsb_eff        = sel ? lsb_hi_s1_reg : lsb_s1_reg;
        round_inc_next = guard_next & (round_next | sticky_next | lsb_eff);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            shifted   <= 1'b0;
`ifdef RNE_INC_EN
            round_inc <= 1'b0;
`endif
        end else if (advance) begin
            out_valid <= v1_reg;
            guard     <= guard_next;
            round_bit <= round_next;
            sticky    <= sticky_next;
            shifted   <= sel;
`ifdef RNE_INC_EN
            round_inc <= round_inc_next;
`endif
        end
    end

endmodule

// File: tb/tb_grs_pipe.sv
// -----------------------------------------------------------------------------
// tb_grs_pipe -- self-checking bench for grs_pipe (TAIL_W=23, EZ_LEAD=2)
//
// Stimulus tasks push an expected result for each accepted beat. A negedge
// monitor pops and compares each beat the DUT hands downstream. Scenario
// tasks add their own direct checks (reset values, latency, stall behaviour).
// -----------------------------------------------------------------------------
module tb_grs_pipe;

    localparam int TAIL_W = 23;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TAIL_W-1:0] tail = '0;
    logic              lsb_in = 1'b0;
    logic              Mul_MSB = 1'b0;
    logic              Ez_add_MSB = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              guard;
    logic              round_bit;
    logic              sticky;
    logic              shifted;
`ifdef RNE_INC_EN
    logic              lsb_hi = 1'b0;
    logic              round_inc;
`endif

    grs_pipe #(.TAIL_W(TAIL_W), .EZ_LEAD(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tail       (tail),
        .lsb_in     (lsb_in),
        .Mul_MSB    (Mul_MSB),
        .Ez_add_MSB (Ez_add_MSB),
`ifdef RNE_INC_EN
        .lsb_hi     (lsb_hi),
        .round_inc  (round_inc),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .guard      (guard),
        .round_bit  (round_bit),
        .sticky     (sticky),
        .shifted    (shifted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic g;
        logic r;
        logic s;
        logic sh;
        logic ri;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_m;
    int   total  = 0;
    int   bad    = 0;
    int   popped = 0;
    // Ez_add_MSB history in advances: e1 = one advance ago, e2 = two ago.
    logic e1 = 1'b0;
    logic e2 = 1'b0;

    function automatic exp_t model(input logic [TAIL_W-1:0] t, input logic l,
                                   input logic m, input logic ez, input logic lh);
        exp_t e;
        logic s;
        s = m | ez;
        if (!s) begin
            e.g = t[22];
            e.r = t[21];
            e.s = (t & 23'h1FFFFF) != 0;
        end else begin
            e.g = l;
            e.r = t[22];
            e.s = (t & 23'h3FFFFF) != 0;
        end
        e.sh = s;
        e.ri = e.g & (e.r | e.s | (s ? lh : l));
        return e;
    endfunction

    task automatic set_in(input logic iv, input logic [TAIL_W-1:0] t, input logic l,
                          input logic m, input logic ez, input logic ordy);
        in_valid   = iv;
        tail       = t;
        lsb_in     = l;
        Mul_MSB    = m;
        Ez_add_MSB = ez;
        out_ready  = ordy;
    endtask

    // Run one clock. At the negedge, record the handshake and push the expected
    // result of any accepted beat. Return at posedge+1.
    task automatic tick(output logic acc);
        logic lh;
        @(negedge CLK);
        acc = in_ready;
`ifdef RNE_INC_EN
        lh = lsb_hi;
`else
        lh = 1'b0;
`endif
        if (in_ready) begin
            if (in_valid) exp_q.push_back(model(tail, lsb_in, Mul_MSB, e2, lh));
            e2 = e1;
            e1 = Ez_add_MSB;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick(acc);
        end
    endtask

    // Scoreboard monitor: compare every beat taken by the downstream.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stale_beat: out_valid=1 with no beat outstanding (g=%b r=%b s=%b sh=%b)",
                         guard, round_bit, sticky, shifted);
            end else begin
                exp_m = exp_q.pop_front();
                popped++;
                if ({guard, round_bit, sticky, shifted} !== {exp_m.g, exp_m.r, exp_m.s, exp_m.sh}) begin
                    bad++;
                    $display("FAIL beat%0d_grs: got g=%b r=%b s=%b sh=%b want g=%b r=%b s=%b sh=%b",
                             popped, guard, round_bit, sticky, shifted,
                             exp_m.g, exp_m.r, exp_m.s, exp_m.sh);
                end
                $display("beat %0d: g=%b r=%b s=%b sh=%b", popped, guard, round_bit, sticky, shifted);
`ifdef RNE_INC_EN
                total++;
                if (round_inc !== exp_m.ri) begin
                    bad++;
                    $display("FAIL beat%0d_round_inc: got %b want %b", popped, round_inc, exp_m.ri);
                end
`endif
            end
        end
    end

    task automatic check_cleared(input string name);
        total++;
        if ({out_valid, guard, round_bit, sticky, shifted} !== 5'b0) begin
            bad++;
            $display("FAIL %s: got v=%b g=%b r=%b s=%b sh=%b want all 0",
                     name, out_valid, guard, round_bit, sticky, shifted);
        end
    endtask

    task automatic test_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_cleared("reset_outputs");
        RST = 1'b0;
        exp_q.delete();
        e1 = 1'b0;
        e2 = 1'b0;
        @(posedge CLK);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        check_cleared("after_reset_outputs");
    endtask

    task automatic test_latency();
        logic acc;
        idle(2);
        set_in(1'b1, 23'h000001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(acc);
        total++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_1: got acc=%b out_valid=%b want acc=1 out_valid=0", acc, out_valid);
        end
        set_in(1'b1, 23'h000001, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(acc);
        total++;
        if (out_valid !== 1'b1 || sticky !== 1'b1 || shifted !== 1'b0) begin
            bad++;
            $display("FAIL latency_2: got v=%b s=%b sh=%b want v=1 s=1 sh=0", out_valid, sticky, shifted);
        end
        idle(3);
    endtask

    task automatic test_ez_align();
        logic acc;
        // Flag two advances ahead: applies to the beat.
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1); tick(acc);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);
        set_in(1'b1, 23'h400000, 1'b1, 1'b0, 1'b0, 1'b1); tick(acc);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);
        total++;
        if (out_valid !== 1'b1 || shifted !== 1'b1 || guard !== 1'b1 || round_bit !== 1'b1 || sticky !== 1'b0) begin
            bad++;
            $display("FAIL ez_lead2: got v=%b sh=%b g=%b r=%b s=%b want v=1 sh=1 g=1 r=1 s=0",
                     out_valid, shifted, guard, round_bit, sticky);
        end
        // Flag one advance ahead: must not apply.
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1); tick(acc);
        set_in(1'b1, 23'h400000, 1'b1, 1'b0, 1'b0, 1'b1); tick(acc);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);
        total++;
        if (out_valid !== 1'b1 || shifted !== 1'b0 || guard !== 1'b1 || round_bit !== 1'b0) begin
            bad++;
            $display("FAIL ez_lead1: got v=%b sh=%b g=%b r=%b want v=1 sh=0 g=1 r=0",
                     out_valid, shifted, guard, round_bit);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [TAIL_W-1:0] bt[4];
        logic              bl[4];
        logic              bm[4];
        logic [3:0]        snap;
        logic              acc;
        logic              iv;
        int                idx = 0;
        int                start = popped;
        for (int i = 0; i < 4; i++) begin
            bt[i] = TAIL_W'($urandom);
            bl[i] = 1'($urandom);
            bm[i] = 1'($urandom);
        end
        snap = '0;
        for (int c = 0; c < 30; c++) begin
            iv = (idx < 4);
            if (iv) set_in(1'b1, bt[idx], bl[idx], bm[idx], 1'($urandom), !(c >= 2 && c <= 4));
            else    set_in(1'b0, '0, 1'b0, 1'b0, 1'($urandom), 1'b1);
            #1;
            if (c >= 2 && c <= 4) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_in_ready c=%0d: got in_ready=%b out_valid=%b want 0/1",
                             c, in_ready, out_valid);
                end
                if (c == 2) snap = {guard, round_bit, sticky, shifted};
                else begin
                    total++;
                    if ({guard, round_bit, sticky, shifted} !== snap) begin
                        bad++;
                        $display("FAIL stall_hold c=%0d: got %b want %b", c,
                                 {guard, round_bit, sticky, shifted}, snap);
                    end
                end
            end
            tick(acc);
            if (acc && iv) idx++;
            if (idx == 4 && exp_q.size() == 0) break;
        end
        total++;
        if (popped - start != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats out, %0d pending want 4 out, 0 pending",
                     popped - start, exp_q.size());
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        logic acc;
        int   start;
        set_in(1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b1, 1'b1); tick(acc);
        set_in(1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b1, 1'b1); tick(acc);
        RST = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        e1 = 1'b0;
        e2 = 1'b0;
        check_cleared("midflight_reset");
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midflight_in_ready: got %b want 1", in_ready);
        end
        // First beat after reset must see a cleared delay line (sel=0).
        start = popped;
        set_in(1'b1, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);
        idle(6);
        total++;
        if (popped - start != 1) begin
            bad++;
            $display("FAIL midflight_count: got %0d beats want 1", popped - start);
        end
    endtask

`ifdef RNE_INC_EN
    task automatic test_rne();
        logic acc;
        lsb_hi = 1'b0;
        set_in(1'b1, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);   // tie, even  -> 0
        set_in(1'b1, 23'h400000, 1'b1, 1'b0, 1'b0, 1'b1); tick(acc);   // tie, odd   -> 1
        set_in(1'b1, 23'h400001, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);   // sticky     -> 1
        lsb_hi = 1'b1;
        set_in(1'b1, 23'h000000, 1'b1, 1'b1, 1'b0, 1'b1); tick(acc);   // shifted, odd -> 1
        lsb_hi = 1'b0;
        set_in(1'b1, 23'h000000, 1'b1, 1'b1, 1'b0, 1'b1); tick(acc);   // shifted, even -> 0
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1); tick(acc);
        total++;
        if (round_inc !== 1'b0) begin
            bad++;
            $display("FAIL rne_even_shifted: got %b want 0", round_inc);
        end
        idle(3);
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_ez_align();
        test_back_to_back();
        test_reset_midflight();
`ifdef RNE_INC_EN
        test_rne();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
